// File: rtl/controller.sv
// rtl/controller.sv - RV32I main decoder with a sequencer for the UMUL and MEMC custom instructions
// Decode is combinational from instr, or from the latched opcode/f3 while a custom op is busy.
module controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        zero,
  input  logic [31:0] instr,
  output logic [1:0]  pc_src,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic        alu_src_1,
  output logic        alu_src_2,
  output logic [3:0]  alu_control,
  output logic [2:0]  ls_src,
  output logic        data_write_en,
  output logic        reg_write_en,
  output logic        multi_cy
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_UMUL = 2'd1;
  localparam logic [1:0] ST_MEMC = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_UMUL   = 7'b0110000;
  localparam logic [6:0] OP_MEMC   = 7'b0000000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [6:0] op_q, op_d;
  logic [2:0] f3_q, f3_d;

  logic       busy;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       umul_last;
  logic [3:0] alu_f3;
  logic       unused_instr_bits;

  assign busy      = (state_q != ST_RUN);
  assign opcode    = busy ? op_q : instr[6:0];
  assign f3        = busy ? f3_q : instr[14:12];
  assign f7b5      = instr[30];
  assign umul_last = (state_q == ST_UMUL) && (cnt_q == 2'd2);
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    f3_d    = f3_q;
    case (state_q)
      ST_RUN: begin
        if (instr[6:0] == OP_UMUL || instr[6:0] == OP_MEMC) begin
          state_d = (instr[6:0] == OP_UMUL) ? ST_UMUL : ST_MEMC;
          cnt_d   = 2'd0;
          op_d    = instr[6:0];
          f3_d    = instr[14:12];
        end
      end
      // The RUN cycle that sees the opcode is cycle 1; BUSY cnt 0..2 covers cycles 2..4.
      ST_UMUL: begin
        if (cnt_q == 2'd2) begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_MEMC: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
    end
  end

  always_comb begin
    case (f3)
      3'b000:  alu_f3 = (opcode == OP_REG && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  always_comb begin
    pc_src        = 2'b00;
    result_src    = 2'b00;
    imm_src       = 2'b00;
    alu_src_1     = 1'b0;
    alu_src_2     = 1'b0;
    alu_control   = ALU_ADD;
    ls_src        = 3'b010;
    data_write_en = 1'b0;
    reg_write_en  = 1'b0;
    multi_cy      = 1'b0;
    case (opcode)
      OP_LUI: begin
        reg_write_en = 1'b1;
        imm_src      = 2'b11;
        result_src   = 2'b11;
      end
      OP_AUIPC: begin
        reg_write_en = 1'b1;
        imm_src      = 2'b11;
        alu_src_1    = 1'b1;
        alu_src_2    = 1'b1;
      end
      OP_JAL: begin
        reg_write_en = 1'b1;
        imm_src      = 2'b11;
        result_src   = 2'b10;
        pc_src       = 2'b01;
      end
      OP_JALR: begin
        reg_write_en = 1'b1;
        alu_src_2    = 1'b1;
        result_src   = 2'b10;
        pc_src       = 2'b10;
      end
      OP_BRANCH: begin
        imm_src     = 2'b10;
        alu_control = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        // BEQ/BGE/BGEU take on zero=1, the inverted forms on zero=0.
        if ((f3[2] || !f3[1]) && (zero ^ f3[0] ^ f3[2]))
          pc_src = 2'b01;
      end
      OP_LOAD: begin
        reg_write_en = 1'b1;
        alu_src_2    = 1'b1;
        result_src   = 2'b01;
        ls_src       = f3;
      end
      OP_STORE: begin
        data_write_en = 1'b1;
        imm_src       = 2'b01;
        alu_src_2     = 1'b1;
        ls_src        = f3;
      end
      OP_IMM: begin
        reg_write_en = 1'b1;
        alu_src_2    = 1'b1;
        alu_control  = alu_f3;
      end
      OP_REG: begin
        reg_write_en = 1'b1;
        alu_control  = alu_f3;
      end
      OP_UMUL: begin
        alu_control = ALU_MUL;
        if (umul_last) begin
          reg_write_en = 1'b1;
        end else begin
          multi_cy = 1'b1;
          pc_src   = 2'b11;
        end
      end
      OP_MEMC: begin
        if (state_q == ST_MEMC) begin
          data_write_en = 1'b1;
          alu_control   = ALU_PASS;
        end else begin
          multi_cy  = 1'b1;
          pc_src    = 2'b11;
          alu_src_2 = 1'b1;
        end
      end
      default: ls_src = 3'b000;
    endcase
    if (rst) begin
      pc_src        = 2'b00;
      result_src    = 2'b00;
      imm_src       = 2'b00;
      alu_src_1     = 1'b0;
      alu_src_2     = 1'b0;
      alu_control   = 4'b0000;
      ls_src        = 3'b000;
      data_write_en = 1'b0;
      reg_write_en  = 1'b0;
      multi_cy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed bench for controller
// Output vector: {pc_src, result_src, imm_src, alu_src_1, alu_src_2, alu_control, ls_src, dwe, rwe, multi_cy}.
module tb_controller;

  logic        clk;
  logic        rst;
  logic        zero;
  logic [31:0] instr;
  logic [1:0]  pc_src;
  logic [1:0]  result_src;
  logic [1:0]  imm_src;
  logic        alu_src_1;
  logic        alu_src_2;
  logic [3:0]  alu_control;
  logic [2:0]  ls_src;
  logic        data_write_en;
  logic        reg_write_en;
  logic        multi_cy;
  logic [17:0] outv;

  int checks = 0;
  int failures = 0;

  controller dut (
    .clk(clk), .rst(rst), .zero(zero), .instr(instr),
    .pc_src(pc_src), .result_src(result_src), .imm_src(imm_src),
    .alu_src_1(alu_src_1), .alu_src_2(alu_src_2), .alu_control(alu_control),
    .ls_src(ls_src), .data_write_en(data_write_en), .reg_write_en(reg_write_en),
    .multi_cy(multi_cy)
  );

  assign outv = {pc_src, result_src, imm_src, alu_src_1, alu_src_2, alu_control,
                 ls_src, data_write_en, reg_write_en, multi_cy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ev(input logic [1:0] pc, input logic [1:0] rs,
                                     input logic [1:0] im, input logic a1, input logic a2,
                                     input logic [3:0] alu, input logic [2:0] ls,
                                     input logic dwe, input logic rwe, input logic mc);
    return {pc, rs, im, a1, a2, alu, ls, dwe, rwe, mc};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    checks++;
    assert (outv === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, outv, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic z);
    @(negedge clk);
    instr = i;
    zero  = z;
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    zero  = 1'b0;
    instr = 32'h00232BB7;
    #1;
    check("reset_outputs", 18'd0);
    @(negedge clk);
    #1;
    check("reset_hold", 18'd0);
    @(negedge clk);
    rst = 1'b0;

    apply(32'h00232BB7, 1'b0); check("lui",   ev(2'b00, 2'b11, 2'b11, 0, 0, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h00232C17, 1'b0); check("auipc", ev(2'b00, 2'b00, 2'b11, 1, 1, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h0080006F, 1'b0); check("jal",   ev(2'b01, 2'b10, 2'b11, 0, 0, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h00840667, 1'b0); check("jalr",  ev(2'b10, 2'b10, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h00418463, 1'b1); check("beq_taken",   ev(2'b01, 2'b00, 2'b10, 0, 0, 4'b0001, 3'b010, 0, 0, 0));
    apply(32'h00418463, 1'b0); check("beq_not",     ev(2'b00, 2'b00, 2'b10, 0, 0, 4'b0001, 3'b010, 0, 0, 0));
    apply(32'h00419463, 1'b0); check("bne_taken",   ev(2'b01, 2'b00, 2'b10, 0, 0, 4'b0001, 3'b010, 0, 0, 0));
    apply(32'h00419463, 1'b1); check("bne_not",     ev(2'b00, 2'b00, 2'b10, 0, 0, 4'b0001, 3'b010, 0, 0, 0));
    apply(32'h00004063, 1'b0); check("blt_taken",   ev(2'b01, 2'b00, 2'b10, 0, 0, 4'b1000, 3'b010, 0, 0, 0));
    apply(32'h00007063, 1'b0); check("bgeu_not",    ev(2'b00, 2'b00, 2'b10, 0, 0, 4'b1001, 3'b010, 0, 0, 0));
    apply(32'h00007063, 1'b1); check("bgeu_taken",  ev(2'b01, 2'b00, 2'b10, 0, 0, 4'b1001, 3'b010, 0, 0, 0));
    apply(32'h00C22583, 1'b0); check("lw",    ev(2'b00, 2'b01, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h00F19AA3, 1'b0); check("sh",    ev(2'b00, 2'b00, 2'b01, 0, 1, 4'b0000, 3'b001, 1, 0, 0));
    apply(32'h0100D903, 1'b0); check("lhu",   ev(2'b00, 2'b01, 2'b00, 0, 1, 4'b0000, 3'b101, 0, 1, 0));
    apply(32'h00090013, 1'b0); check("addi",  ev(2'b00, 2'b00, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h40005013, 1'b0); check("srai",  ev(2'b00, 2'b00, 2'b00, 0, 1, 4'b0111, 3'b010, 0, 1, 0));
    apply(32'h40000013, 1'b0); check("addi_b30", ev(2'b00, 2'b00, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));
    apply(32'h00232433, 1'b0); check("slt",   ev(2'b00, 2'b00, 2'b00, 0, 0, 4'b1000, 3'b010, 0, 1, 0));
    apply(32'h40000033, 1'b0); check("sub",   ev(2'b00, 2'b00, 2'b00, 0, 0, 4'b0001, 3'b010, 0, 1, 0));
    apply(32'h0000707F, 1'b1); check("undef_nop", 18'd0);

    apply(32'h002081B0, 1'b0); check("umul_c1", ev(2'b11, 2'b00, 2'b00, 0, 0, 4'b1010, 3'b010, 0, 0, 1));
    apply(32'h00232BB7, 1'b0); check("umul_c2", ev(2'b11, 2'b00, 2'b00, 0, 0, 4'b1010, 3'b010, 0, 0, 1));
    apply(32'h00F19AA3, 1'b1); check("umul_c3", ev(2'b11, 2'b00, 2'b00, 0, 0, 4'b1010, 3'b010, 0, 0, 1));
    apply(32'h00232BB7, 1'b0); check("umul_c4", ev(2'b00, 2'b00, 2'b00, 0, 0, 4'b1010, 3'b010, 0, 1, 0));
    apply(32'h00232BB7, 1'b0); check("after_umul", ev(2'b00, 2'b11, 2'b11, 0, 0, 4'b0000, 3'b010, 0, 1, 0));

    apply(32'h00810A00, 1'b0); check("memc_rd", ev(2'b11, 2'b00, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 0, 1));
    apply(32'h00C22583, 1'b0); check("memc_wr", ev(2'b00, 2'b00, 2'b00, 0, 0, 4'b1111, 3'b010, 1, 0, 0));
    apply(32'h00C22583, 1'b0); check("after_memc", ev(2'b00, 2'b01, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));

    apply(32'h002081B0, 1'b0); check("umul_rst_c1", ev(2'b11, 2'b00, 2'b00, 0, 0, 4'b1010, 3'b010, 0, 0, 1));
    apply(32'h00000013, 1'b0); check("umul_rst_c2", ev(2'b11, 2'b00, 2'b00, 0, 0, 4'b1010, 3'b010, 0, 0, 1));
    rst = 1'b1;
    #1;
    check("umul_rst_abort", 18'd0);
    @(negedge clk);
    rst = 1'b0;
    instr = 32'h00090013;
    #1;
    check("umul_rst_resume", ev(2'b00, 2'b00, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));

    apply(32'h00810A00, 1'b0); check("memc_rst_rd", ev(2'b11, 2'b00, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 0, 1));
    apply(32'h00810A00, 1'b0);
    rst = 1'b1;
    #1;
    check("memc_rst_abort", 18'd0);
    @(negedge clk);
    rst = 1'b0;
    instr = 32'h00C22583;
    #1;
    check("memc_rst_resume", ev(2'b00, 2'b01, 2'b00, 0, 1, 4'b0000, 3'b010, 0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
